// File: rtl/pathfinding_pkg.sv
// Shared pathfinding types: node records, special node ids, queue address width
// and the expansion FSM state encoding.
package pathfinding_pkg;

  localparam int QADDR_W   = 7;
  localparam int NUM_CHILD = 6;

  localparam logic [15:0] NODE_NONE     = 16'd0;
  localparam logic [15:0] NODE_SENTINEL = 16'd800;
  localparam logic [15:0] COST_MAX      = 16'hFFFF;

  typedef struct packed {
    logic [15:0] x_pos;
    logic [15:0] y_pos;
  } map_node;

  typedef struct packed {
    logic [15:0]                 node_id;
    logic [15:0]                 parent_node_id;
    logic [15:0]                 current_cost;
    map_node                     loc;
    logic [NUM_CHILD-1:0][15:0]  child_id;
    logic [NUM_CHILD-1:0][15:0]  distance;
  } node_info;

  localparam int NODE_W = $bits(node_info);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LATCH,
    S_SLOT,
    S_MAP_ADDR,
    S_MAP_WAIT,
    S_MAP_READ,
    S_FIND,
    S_WAIT_FIND,
    S_DECIDE,
    S_WRITE,
    S_DONE
  } expand_state_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? COST_MAX : sum[15:0];
  endfunction

  function automatic logic is_empty_slot(input logic [15:0] id);
    return (id == NODE_NONE) || (id == NODE_SENTINEL);
  endfunction

endpackage

// File: rtl/expand_relax_calc.sv
// Edge relaxation for one child: saturating path cost and the insert/update/drop
// decision against the queue state.
module expand_relax_calc
  import pathfinding_pkg::*;
#(
  parameter int MAX_NODES = 100
) (
  input  logic [15:0]        cur_cost,
  input  logic [15:0]        distance,
  input  logic               queued,
  input  logic [15:0]        queued_cost,
  input  logic [QADDR_W-1:0] tail,
  output logic [15:0]        new_cost,
  output logic               do_write,
  output logic               use_tail,
  output logic               overflow_hit
);

  localparam logic [QADDR_W-1:0] TAIL_LIMIT = QADDR_W'(MAX_NODES);

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    new_cost     = sat_add16(cur_cost, distance);
    do_write     = 1'b0;
    use_tail     = 1'b0;
    overflow_hit = 1'b0;
    if (queued) begin
      // Strictly cheaper only: a tie keeps the entry already in the queue.
      do_write = (new_cost < queued_cost);
    end else if (tail < TAIL_LIMIT) begin
      do_write = 1'b1;
      use_tail = 1'b1;
    end else begin
      overflow_hit = 1'b1;
    end
  end

endmodule

// File: rtl/queue_expand_node.sv
// Expands the current min-cost node: fetches each child, asks queue_child whether it
// is queued, relaxes the edge and writes the queue RAM. Option: QUEUE_EXPAND_PARENT_SKIP_EN.
module queue_expand_node
  import pathfinding_pkg::*;
#(
  parameter int MAX_NODES = 100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [NODE_W-1:0]  current_node,
  input  logic [QADDR_W-1:0] tail_in,
  output logic [15:0]        map_rd_address,
  input  logic [NODE_W-1:0]  map_rd_data,
  output logic               find_child,
  output logic [NODE_W-1:0]  child_node,
  input  logic               child_done,
  input  logic               child_queued,
  input  logic [QADDR_W-1:0] child_address,
  input  logic [NODE_W-1:0]  child_from_queue,
  output logic               wr_en,
  output logic [QADDR_W-1:0] wr_address,
  output logic [NODE_W-1:0]  wr_data,
  output logic               busy,
  output logic               done,
  output logic [QADDR_W-1:0] tail_out,
  output logic               overflow
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_CHILD);

  expand_state_t      state;
  logic [2:0]         idx;
  logic [QADDR_W-1:0] tail;

  node_info           cur;
  node_info           q_entry;
  logic               q_queued;
  logic [QADDR_W-1:0] q_addr;

  logic [15:0]        slot_id;
  logic               skip_slot;
  logic [15:0]        new_cost;
  logic               do_write;
  logic               use_tail;
  logic               overflow_hit;
  node_info           patched;

  logic               unused_cur;
  assign unused_cur = ^{cur.loc, cur.parent_node_id};

  assign slot_id = cur.child_id[idx];

  always_comb begin
    skip_slot = is_empty_slot(slot_id);
`ifdef QUEUE_EXPAND_PARENT_SKIP_EN
    if (slot_id == cur.parent_node_id) skip_slot = 1'b1;
`endif
  end

  expand_relax_calc #(.MAX_NODES(MAX_NODES)) u_relax (
    .cur_cost     (cur.current_cost),
    .distance     (cur.distance[idx]),
    .queued       (q_queued),
    .queued_cost  (q_entry.current_cost),
    .tail         (tail),
    .new_cost     (new_cost),
    .do_write     (do_write),
    .use_tail     (use_tail),
    .overflow_hit (overflow_hit)
  );

  // Only the parent link and the cost change; every other field passes through.
  always_comb begin
    patched                = q_queued ? q_entry : node_info'(child_node);
    patched.parent_node_id = cur.node_id;
    patched.current_cost   = new_cost;
  end

  // NOTE: pure datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) cur <= node_info'(current_node);
    if (state == S_WAIT_FIND && child_done) begin
      q_queued <= child_queued;
      q_addr   <= child_address;
      q_entry  <= node_info'(child_from_queue);
    end
  end

  // NOTE: state and registered outputs use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      idx            <= '0;
      tail           <= '0;
      map_rd_address <= '0;
      find_child     <= 1'b0;
      child_node     <= '0;
      wr_en          <= 1'b0;
      wr_address     <= '0;
      wr_data        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      tail_out       <= '0;
      overflow       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            overflow <= 1'b0;
            tail     <= tail_in;
            state    <= S_LATCH;
          end
        end
        S_LATCH: begin
          idx   <= '0;
          state <= S_SLOT;
        end
        S_SLOT: begin
          if (idx == LAST_IDX) begin
            done     <= 1'b1;
            busy     <= 1'b0;
            tail_out <= tail;
            state    <= S_DONE;
          end else if (skip_slot) begin
            idx <= idx + 3'd1;
          end else begin
            map_rd_address <= slot_id;
            state          <= S_MAP_ADDR;
          end
        end
        S_MAP_ADDR: state <= S_MAP_WAIT;
        // Map memory has two cycles of read latency after the address changes.
        S_MAP_WAIT: state <= S_MAP_READ;
        S_MAP_READ: begin
          child_node <= map_rd_data;
          find_child <= 1'b1;
          state      <= S_FIND;
        end
        S_FIND: begin
          find_child <= 1'b0;
          state      <= S_WAIT_FIND;
        end
        S_WAIT_FIND: begin
          if (child_done) state <= S_DECIDE;
        end
        S_DECIDE: begin
          if (do_write) begin
            wr_en      <= 1'b1;
            wr_address <= use_tail ? tail : q_addr;
            wr_data    <= patched;
            if (use_tail) tail <= tail + 7'd1;
          end
          if (overflow_hit) overflow <= 1'b1;
          state <= S_WRITE;
        end
        S_WRITE: begin
          wr_en <= 1'b0;
          idx   <= idx + 3'd1;
          state <= S_SLOT;
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_queue_expand_node.sv
// Directed bench for queue_expand_node: map-memory and queue_child models plus a
// scoreboard of expected queue RAM writes.
module tb_queue_expand_node;
  import pathfinding_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  node_info     current_node;
  logic [6:0]   tail_in;
  logic [15:0]  map_rd_address;
  node_info     map_rd_data;
  logic         find_child;
  logic [271:0] child_node;
  logic         child_done;
  logic         child_queued;
  logic [6:0]   child_address;
  node_info     child_from_queue;
  logic         wr_en;
  logic [6:0]   wr_address;
  logic [271:0] wr_data;
  logic         busy;
  logic         done;
  logic [6:0]   tail_out;
  logic         overflow;

  queue_expand_node #(.MAX_NODES(100)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .current_node     (current_node),
    .tail_in          (tail_in),
    .map_rd_address   (map_rd_address),
    .map_rd_data      (map_rd_data),
    .find_child       (find_child),
    .child_node       (child_node),
    .child_done       (child_done),
    .child_queued     (child_queued),
    .child_address    (child_address),
    .child_from_queue (child_from_queue),
    .wr_en            (wr_en),
    .wr_address       (wr_address),
    .wr_data          (wr_data),
    .busy             (busy),
    .done             (done),
    .tail_out         (tail_out),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int find_cnt = 0;
  int wr_cnt   = 0;

  bit         child_auto = 1'b1;
  logic       resp_queued;
  logic [6:0] resp_addr;
  node_info   resp_entry;

  node_info map_mem [0:1023];
  node_info map_d1;

  typedef struct {
    logic [6:0] addr;
    node_info   data;
  } wr_exp_t;
  wr_exp_t exp_q[$];
  wr_exp_t exp_e;

  task automatic check(input string tag, input logic [271:0] obs, input logic [271:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic node_info mk(input logic [15:0] id, input logic [15:0] parent,
                                  input logic [15:0] cost);
    node_info n;
    n                = '0;
    n.node_id        = id;
    n.parent_node_id = parent;
    n.current_cost   = cost;
    n.loc.x_pos      = id * 16'd3;
    n.loc.y_pos      = 16'hA000 | id;
    return n;
  endfunction

  function automatic node_info patch(input node_info n, input logic [15:0] parent,
                                     input logic [15:0] cost);
    node_info r;
    r                = n;
    r.parent_node_id = parent;
    r.current_cost   = cost;
    return r;
  endfunction

  task automatic expect_wr(input logic [6:0] addr, input node_info data);
    wr_exp_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Map memory: data appears two cycles after the address changes.
  always @(posedge clk) begin
    map_d1      <= map_mem[map_rd_address[9:0]];
    map_rd_data <= map_d1;
  end

  // queue_child model: answers two cycles after each find_child pulse.
  always begin
    @(negedge clk);
    if (find_child && child_auto) begin
      repeat (2) @(posedge clk);
      #1;
      child_done       = 1'b1;
      child_queued     = resp_queued;
      child_address    = resp_addr;
      child_from_queue = resp_entry;
      @(posedge clk);
      #1;
      child_done       = 1'b0;
      child_queued     = 1'b0;
      child_address    = '0;
      child_from_queue = '0;
    end
  end

  // Monitor: count child searches, pop the scoreboard on every write strobe.
  always @(negedge clk) begin
    if (find_child === 1'b1) find_cnt++;
    if (wr_en === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_wr_en", wr_en, 1'b0);
      end else begin
        exp_e = exp_q.pop_front();
        check("wr_address", wr_address, exp_e.addr);
        check("wr_data", wr_data, exp_e.data);
      end
    end
  end

  task automatic run_expand(input node_info cur, input logic [6:0] t, input string tag);
    bit seen;
    find_cnt     = 0;
    wr_cnt       = 0;
    current_node = cur;
    tail_in      = t;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check({tag, "_busy_after_start"}, busy, 1'b1);
    check({tag, "_overflow_cleared"}, overflow, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic post(input string tag, input int finds, input int wrs,
                      input logic [6:0] tail_exp, input logic ovf_exp);
    check({tag, "_find_count"}, find_cnt, finds);
    check({tag, "_write_count"}, wr_cnt, wrs);
    check({tag, "_tail_out"}, tail_out, tail_exp);
    check({tag, "_overflow"}, overflow, ovf_exp);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    node_info cur, cur2, cur3, cur4, curp;
    bit seen;

    for (int i = 0; i < 1024; i++) map_mem[i] = '0;
    reset            = 1'b1;
    start            = 1'b0;
    current_node     = '0;
    tail_in          = '0;
    child_done       = 1'b0;
    child_queued     = 1'b0;
    child_address    = '0;
    child_from_queue = '0;
    resp_queued      = 1'b0;
    resp_addr        = '0;
    resp_entry       = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_find_child", find_child, 1'b0);
    check("rst_map_rd_address", map_rd_address, 16'd0);
    check("rst_child_node", child_node, '0);
    check("rst_tail_out", tail_out, 7'd0);
    check("rst_overflow", overflow, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    map_mem[7] = mk(16'd7, 16'd99, 16'd555);
    map_mem[7].child_id[0] = 16'd11;
    map_mem[7].distance[0] = 16'd4;
    map_mem[9] = mk(16'd9, 16'd1, 16'd40);

    // Insert a new child at the tail.
    cur = mk(16'd5, 16'd0, 16'd10);
    cur.child_id[1] = 16'd7;
    cur.distance[1] = 16'd3;
    expect_wr(7'd2, patch(map_mem[7], 16'd5, 16'd13));
    run_expand(cur, 7'd2, "ins");
    post("ins", 1, 1, 7'd3, 1'b0);

    // Cheaper path to a queued child: overwrite the queued entry.
    resp_queued = 1'b1;
    resp_addr   = 7'd4;
    resp_entry  = mk(16'd7, 16'd2, 16'd20);
    resp_entry.loc.x_pos   = 16'h1234;
    resp_entry.child_id[2] = 16'h0077;
    expect_wr(7'd4, patch(resp_entry, 16'd5, 16'd13));
    run_expand(cur, 7'd3, "upd");
    post("upd", 1, 1, 7'd3, 1'b0);

    // Queued entry already cheaper: nothing written.
    resp_entry.current_cost = 16'd12;
    run_expand(cur, 7'd3, "rej");
    post("rej", 1, 0, 7'd3, 1'b0);

    // Empty and sentinel slots skipped; equal cost keeps the queued entry.
    cur2 = mk(16'd5, 16'd0, 16'd10);
    cur2.child_id[0] = 16'd0;
    cur2.child_id[1] = 16'd800;
    cur2.distance[1] = 16'd1;
    cur2.child_id[2] = 16'd9;
    cur2.distance[2] = 16'd2;
    resp_queued = 1'b1;
    resp_addr   = 7'd6;
    resp_entry  = mk(16'd9, 16'd3, 16'd12);
    run_expand(cur2, 7'd3, "tie");
    post("tie", 1, 0, 7'd3, 1'b0);
    check("tie_map_rd_address", map_rd_address, 16'd9);

    // Full queue: new child dropped, overflow raised.
    resp_queued = 1'b0;
    resp_entry  = '0;
    run_expand(cur, 7'd100, "full");
    post("full", 1, 0, 7'd100, 1'b1);

    // Saturating cost; also confirms overflow cleared by the accepted start.
    cur3 = mk(16'd5, 16'd0, 16'hFFF0);
    cur3.child_id[4] = 16'd7;
    cur3.distance[4] = 16'h0020;
    expect_wr(7'd10, patch(map_mem[7], 16'd5, 16'hFFFF));
    run_expand(cur3, 7'd10, "sat");
    post("sat", 1, 1, 7'd11, 1'b0);

    // Last free slot taken, the following insert overflows.
    cur4 = mk(16'd21, 16'd0, 16'd100);
    cur4.child_id[0] = 16'd7;
    cur4.distance[0] = 16'd1;
    cur4.child_id[5] = 16'd9;
    cur4.distance[5] = 16'd2;
    expect_wr(7'd99, patch(map_mem[7], 16'd21, 16'd101));
    run_expand(cur4, 7'd99, "edge");
    post("edge", 2, 1, 7'd100, 1'b1);

    // Reset while waiting on the child search abandons the expansion.
    child_auto   = 1'b0;
    find_cnt     = 0;
    wr_cnt       = 0;
    current_node = cur;
    tail_in      = 7'd2;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (find_child === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("rstmid_find_seen", seen, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_wr_en", wr_en, 1'b0);
    reset      = 1'b0;
    child_auto = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("rstmid_no_write", wr_cnt, 0);
    check("rstmid_idle", busy, 1'b0);
    expect_wr(7'd2, patch(map_mem[7], 16'd5, 16'd13));
    run_expand(cur, 7'd2, "post_rst");
    post("post_rst", 1, 1, 7'd3, 1'b0);

    // Child equal to the parent of the expanded node.
    curp = mk(16'd5, 16'd7, 16'd10);
    curp.child_id[1] = 16'd7;
    curp.distance[1] = 16'd3;
`ifdef QUEUE_EXPAND_PARENT_SKIP_EN
    run_expand(curp, 7'd2, "parent");
    post("parent", 0, 0, 7'd2, 1'b0);
`else
    resp_queued = 1'b1;
    resp_addr   = 7'd1;
    resp_entry  = mk(16'd7, 16'd0, 16'd5);
    run_expand(curp, 7'd2, "parent");
    post("parent", 1, 0, 7'd2, 1'b0);
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
